row_collapser: RTL and testbench

ROW_COLLAPSER -- requirements
Module: row_collapser

---
 rtl/tetris_pkg.sv | 24 ++
 rtl/row_full_detect.sv | 14 +
 rtl/row_collapser.sv | 135 +++++++++++++
 tb/tb_row_collapser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board-datapath definitions: default board geometry, collapse FSM
// state encoding and a saturating counter helper.
package tetris_pkg;

  localparam int unsigned ROWS_DEF = 23;
  localparam int unsigned COLS_DEF = 10;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned LC_W     = 3;
  localparam int unsigned ST_W     = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SC_RD = 3'd1;
  localparam logic [2:0] ST_SC_CHK = 3'd2;
  localparam logic [2:0] ST_SH_RD = 3'd3;
  localparam logic [2:0] ST_SH_WR = 3'd4;
  localparam logic [2:0] ST_CLR   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // Increment that sticks at all-ones.
  function automatic logic [LC_W-1:0] sat_inc(input logic [LC_W-1:0] v);
    return (v == '1) ? v : v + LC_W'(1);
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// Full-row test for one board row word.
// Ports:
//   row    - row word, one bit per column
//   full_c - high when every column of the row is occupied (combinational)
module row_full_detect #(
  parameter int unsigned COLS = 10
) (
  input  logic [COLS-1:0] row,
  output logic            full_c
);

  assign full_c = &row;

endmodule

// File: rtl/row_collapser.sv
// Line-clear sweep for the board RAM. Scans rows bottom-up; each full row is
// removed by copying every row above it down by one and clearing row 0, then
// the same index is rescanned to catch the row that just moved in.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   start         - request a sweep (accepted only when idle)
//   busy          - sweep in progress (low in the done cycle)
//   done          - one-cycle completion pulse
//   lines_cleared - rows removed in the last sweep, saturates at 7
//   mem_addr      - board RAM row address
//   mem_rdata     - RAM read data, one cycle after mem_addr
//   mem_we        - RAM write enable
//   mem_wdata     - RAM write data
module row_collapser
  import tetris_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [LC_W-1:0]   lines_cleared,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COLS-1:0]   mem_rdata,
  output logic              mem_we,
  output logic [COLS-1:0]   mem_wdata
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [LC_W-1:0]   lc_q, lc_d;
  logic              busy_d, done_d, we_d;
  logic [ADDR_W-1:0] addr_d;
  logic              full_c;

  row_full_detect #(.COLS(COLS)) u_full (
    .row    (mem_rdata),
    .full_c (full_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      row_q    <= '0;
      r_q      <= '0;
      lc_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      r_q      <= r_d;
      lc_q     <= lc_d;
      busy     <= busy_d;
      done     <= done_d;
      mem_we   <= we_d;
      mem_addr <= addr_d;
    end
  end

  // Next state; outputs are derived from the next state so they line up
  // with the state register.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    r_d     = r_q;
    lc_d    = lc_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = ADDR_W'(ROWS - 1);
          lc_d    = '0;
          state_d = ST_SC_RD;
        end
      end
      ST_SC_RD: state_d = ST_SC_CHK;
      ST_SC_CHK: begin
        if (full_c) begin
          if (row_q == '0) begin
            state_d = ST_CLR;
          end else begin
            r_d     = row_q;
            state_d = ST_SH_RD;
          end
        end else if (row_q == '0) begin
          state_d = ST_DONE;
        end else begin
          row_d   = row_q - ADDR_W'(1);
          state_d = ST_SC_RD;
        end
      end
      ST_SH_RD: state_d = ST_SH_WR;
      ST_SH_WR: begin
        if (r_q == ADDR_W'(1)) begin
          state_d = ST_CLR;
        end else begin
          r_d     = r_q - ADDR_W'(1);
          state_d = ST_SH_RD;
        end
      end
      ST_CLR: begin
        lc_d    = sat_inc(lc_q);
        state_d = ST_SC_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    we_d   = (state_d == ST_SH_WR) || (state_d == ST_CLR);

    case (state_d)
      ST_SC_RD: addr_d = row_d;
      ST_SH_RD: addr_d = r_d - ADDR_W'(1);
      ST_SH_WR: addr_d = r_d;
      default:  addr_d = '0;
    endcase
  end

  assign lines_cleared = lc_q;

  // Read data only becomes valid in SH_WR itself, so it is forwarded straight
  // to the write port; CLR and all other states drive zeros.
  assign mem_wdata = (state_q == ST_SH_WR) ? mem_rdata : '0;

endmodule

// File: tb/tb_row_collapser.sv
// Directed bench for row_collapser with a synchronous-read board RAM model.
module tb_row_collapser;

  localparam int unsigned ROWS = 23;
  localparam int unsigned COLS = 10;
  localparam logic [COLS-1:0] FULL = '1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [2:0]      lines_cleared;
  logic [4:0]      mem_addr;
  logic [COLS-1:0] mem_rdata;
  logic            mem_we;
  logic [COLS-1:0] mem_wdata;

  int n_chk = 0;
  int n_bad = 0;

  row_collapser #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata)
  );

  always #5 clk = ~clk;

  // Board RAM: synchronous read, write on enable, bench backdoor loader.
  logic [COLS-1:0] mem [ROWS];
  logic            load_en;
  logic [4:0]      load_addr;
  logic [COLS-1:0] load_data;
  int              wr_cnt = 0;

  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  logic [COLS-1:0] init_b [ROWS];
  logic [COLS-1:0] exp_b  [ROWS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic zero_boards();
    for (int i = 0; i < ROWS; i++) begin
      init_b[i] = '0;
      exp_b[i]  = '0;
    end
  endtask

  task automatic load_board();
    for (int i = 0; i < ROWS; i++) begin
      @(negedge clk);
      load_addr = 5'(i);
      load_data = init_b[i];
      load_en   = 1'b1;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic chk_rows(input string tag);
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("%s_row%0d", tag, i), 32'(mem[i]), 32'(exp_b[i]));
  endtask

  // Start a sweep, optionally holding start high for 'hold' busy cycles,
  // then check latency, done pulse shape, busy, count and write total.
  task automatic run_sweep(input string tag, input int exp_cyc, input int exp_lc,
                           input int exp_wr, input int hold);
    int cyc;
    int wr0;
    bit seen;
    wr0 = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc  = 1;
    seen = 1'b0;
    if (hold == 0) start = 1'b0;
    chk({tag, "_busy_first"}, 32'(busy), 32'd1);
    while (!seen && cyc < 3000) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > hold) start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_lines"}, 32'(lines_cleared), 32'(exp_lc));
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_lines_hold"}, 32'(lines_cleared), 32'(exp_lc));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    int wait_cyc;
    int done_hits;
    rst       = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Empty board: pure scan, no writes.
    zero_boards();
    load_board();
    run_sweep("empty", 47, 0, 0, 0);
    chk_rows("empty");

    // Bottom row full, pattern above drops into it; start held while busy.
    zero_boards();
    init_b[22] = FULL;
    init_b[21] = 10'h155;
    exp_b[22]  = 10'h155;
    load_board();
    run_sweep("one", 94, 1, 23, 5);
    chk_rows("one");

    // Four stacked full rows.
    zero_boards();
    for (int i = 19; i < 23; i++) init_b[i] = FULL;
    load_board();
    run_sweep("four", 235, 4, 92, 0);
    chk_rows("four");

    // Two separated full rows with a partial row between them.
    zero_boards();
    init_b[22] = FULL;
    init_b[21] = 10'h0F0;
    init_b[20] = FULL;
    exp_b[22]  = 10'h0F0;
    load_board();
    run_sweep("two", 139, 2, 45, 0);
    chk_rows("two");

    // Only the top row full: cleared directly, single write.
    zero_boards();
    init_b[0] = FULL;
    load_board();
    run_sweep("top", 50, 1, 1, 0);
    chk_rows("top");

    // Whole board full: counter saturates at 7.
    zero_boards();
    for (int i = 0; i < ROWS; i++) init_b[i] = FULL;
    load_board();
    run_sweep("sat", 1128, 7, 529, 0);
    chk_rows("sat");

    // Reset during the first shift write aborts before anything is written.
    zero_boards();
    init_b[22] = FULL;
    init_b[21] = 10'h155;
    exp_b[22]  = 10'h155;
    load_board();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc = 0;
    while (!(mem_we && mem_addr != 5'd0) && wait_cyc < 200) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    chk("abort_reach_shwr", 32'(mem_we && mem_addr == 5'd22), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_hits = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) done_hits++;
    end
    chk("abort_no_done", 32'(done_hits), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_sweep("after_abort", 94, 1, 23, 0);
    chk_rows("after_abort");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
